// File: rtl/pipeline_elastic.sv
// Elastic valid/ready pipeline built from NUM_STAGES two-entry skid slices.
// Define PIPE_ELASTIC_OCC_EN to add the registered 'occupancy' word-count output.
module pipeline_elastic #(
  parameter int NUM_STAGES = 3,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready
`ifdef PIPE_ELASTIC_OCC_EN
  ,
  output logic [$clog2(2*NUM_STAGES+1)-1:0] occupancy
`endif
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_FULL  = 2'b01,
    ST_SKID  = 2'b10
  } stage_st_e;

  stage_st_e             st_q [NUM_STAGES];
  stage_st_e             st_d [NUM_STAGES];
  logic [DATA_WIDTH-1:0] md_q [NUM_STAGES];
  logic [DATA_WIDTH-1:0] md_d [NUM_STAGES];
  logic [DATA_WIDTH-1:0] sd_q [NUM_STAGES];
  logic [DATA_WIDTH-1:0] sd_d [NUM_STAGES];
  logic [DATA_WIDTH-1:0] up_d_s [NUM_STAGES];
  logic [NUM_STAGES-1:0] up_v_s;
  logic [NUM_STAGES-1:0] dn_s;
  logic                  in_ready_q, in_ready_d;
  logic                  out_valid_q, out_valid_d;

  // Each stage's ready toward its upstream neighbour comes only from that stage's state flops.
  for (genvar g = 0; g < NUM_STAGES; g++) begin : g_chain
    if (g == 0) begin : g_head
      assign up_v_s[g] = in_valid;
      assign up_d_s[g] = in_data;
    end else begin : g_body
      assign up_v_s[g] = (st_q[g-1] != ST_EMPTY);
      assign up_d_s[g] = md_q[g-1];
    end
    if (g == NUM_STAGES - 1) begin : g_tail
      assign dn_s[g] = out_ready;
    end else begin : g_mid
      assign dn_s[g] = (st_q[g+1] != ST_SKID);
    end
  end

  // Next state of every slice.
  always_comb begin
    for (int k = 0; k < NUM_STAGES; k++) begin
      st_d[k] = st_q[k];
      md_d[k] = md_q[k];
      sd_d[k] = sd_q[k];
      case (st_q[k])
        ST_EMPTY: begin
          if (up_v_s[k]) begin
            st_d[k] = ST_FULL;
            md_d[k] = up_d_s[k];
          end else begin
            st_d[k] = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (up_v_s[k] && dn_s[k]) begin
            md_d[k] = up_d_s[k];
          end else if (up_v_s[k] && !dn_s[k]) begin
            st_d[k] = ST_SKID;
            sd_d[k] = up_d_s[k];
          end else if (!up_v_s[k] && dn_s[k]) begin
            st_d[k] = ST_EMPTY;
          end else begin
            st_d[k] = ST_FULL;
          end
        end
        ST_SKID: begin
          // Upstream is held off while skidding, so up_v_s is not looked at here.
          if (dn_s[k]) begin
            st_d[k] = ST_FULL;
            md_d[k] = sd_q[k];
          end else begin
            st_d[k] = ST_SKID;
          end
        end
        default: begin
          st_d[k] = ST_EMPTY;
        end
      endcase
    end
    in_ready_d  = (st_d[0] != ST_SKID);
    out_valid_d = (st_d[NUM_STAGES-1] != ST_EMPTY);
  end

  // State, payload and registered handshake outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < NUM_STAGES; k++) begin
        st_q[k] <= ST_EMPTY;
        md_q[k] <= '0;
        sd_q[k] <= '0;
      end
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_STAGES; k++) begin
        st_q[k] <= st_d[k];
        md_q[k] <= md_d[k];
        sd_q[k] <= sd_d[k];
      end
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = md_q[NUM_STAGES-1];

`ifdef PIPE_ELASTIC_OCC_EN
  localparam int OCC_W = $clog2(2*NUM_STAGES+1);

  logic [OCC_W-1:0] occ_q, occ_d;
  logic             in_xfer_s, out_xfer_s;

  assign in_xfer_s  = in_valid & in_ready_q;
  assign out_xfer_s = out_valid_q & out_ready;

  // Word count moves only when exactly one side transfers.
  always_comb begin
    occ_d = occ_q;
    case ({in_xfer_s, out_xfer_s})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase
  end

  // Occupancy register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign occupancy = occ_q;
`endif

endmodule

// File: tb/tb_pipeline_elastic.sv
// Self-checking bench for pipeline_elastic (NUM_STAGES=2): directed scenarios plus
// randomized traffic scored against a queue model of the pipeline contents.
module tb_pipeline_elastic;

  localparam int NS = 2;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rstn;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;
`ifdef PIPE_ELASTIC_OCC_EN
  localparam int OW = $clog2(2*NS+1);
  logic [OW-1:0] occupancy;
`endif

  int            checks = 0;
  int            errors = 0;
  int            bad_seen = 0;
  logic [DW-1:0] sb_q [$];

  pipeline_elastic #(.NUM_STAGES(NS), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready)
`ifdef PIPE_ELASTIC_OCC_EN
    ,
    .occupancy (occupancy)
`endif
  );

  always #5 clk = ~clk;

  // Queue model: words accepted but not yet delivered, checked every negedge.
  initial begin : monitor
    logic          prev_stall;
    logic [DW-1:0] prev_data;
    logic [DW-1:0] exp_w;
`ifdef PIPE_ELASTIC_OCC_EN
    logic [OW-1:0] occ_exp;
`endif
    prev_stall = 1'b0;
    prev_data  = '0;
    forever begin
      @(negedge clk);
      if (rstn !== 1'b1) begin
        sb_q.delete();
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          checks++;
          if (out_valid !== 1'b1 || out_data !== prev_data) begin
            errors++;
            $display("FAIL stall_hold: out_valid=%b out_data=%h, required 1 and %h", out_valid, out_data, prev_data);
          end
        end
`ifdef PIPE_ELASTIC_OCC_EN
        occ_exp = OW'(sb_q.size());
        checks++;
        if (occupancy !== occ_exp) begin
          errors++;
          $display("FAIL occupancy: got %0d, required %0d", occupancy, occ_exp);
        end
`endif
        checks++;
        if (sb_q.size() > 2*NS || (sb_q.size() == 2*NS && in_ready !== 1'b0)) begin
          errors++;
          $display("FAIL capacity: held=%0d in_ready=%b, required held<=%0d and in_ready=0 when full", sb_q.size(), in_ready, 2*NS);
        end
        if (out_valid === 1'b1 && out_data === 16'h0BAD) bad_seen++;
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
          checks++;
          if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL spurious_output: got %h, required no word (model empty)", out_data);
          end else begin
            exp_w = sb_q.pop_front();
            if (out_data !== exp_w) begin
              errors++;
              $display("FAIL order: got %h, required %h", out_data, exp_w);
            end
          end
        end
        if (in_valid === 1'b1 && in_ready === 1'b1) sb_q.push_back(in_data);
        prev_stall = (out_valid === 1'b1 && out_ready === 1'b0);
        prev_data  = out_data;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1, "timeout");
  end

  task automatic to_drive();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    #20;
    for (int pass = 0; pass < 2; pass++) begin
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 16'h0000) begin
        errors++;
        $display("FAIL reset_state%0d: in_ready=%b out_valid=%b out_data=%h, required 1 0 0000", pass, in_ready, out_valid, out_data);
      end
`ifdef PIPE_ELASTIC_OCC_EN
      checks++;
      if (occupancy !== '0) begin
        errors++;
        $display("FAIL reset_occ%0d: got %0d, required 0", pass, occupancy);
      end
`endif
      if (pass == 0) begin
        #2 rstn = 1'b1;
        @(negedge clk);
      end
    end
  endtask

  task automatic test_flow();
    logic [DW-1:0] exp_d;
    int j;
    for (int i = 0; i < 6; i++) begin
      to_drive();
      out_ready = 1'b1;
      in_valid  = (i < 3);
      in_data   = 16'(i + 1);
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL flow_ready: cycle %0d in_ready=%b, required 1", i, in_ready);
      end
      j = i - NS;
      exp_d = 16'(j + 1);
      checks++;
      if (j >= 0 && j < 3) begin
        if (out_valid !== 1'b1 || out_data !== exp_d) begin
          errors++;
          $display("FAIL flow_latency: cycle %0d valid=%b data=%h, required 1 %h", i, out_valid, out_data, exp_d);
        end
      end else if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL flow_latency: cycle %0d valid=%b, required 0", i, out_valid);
      end
    end
    to_drive();
    in_valid = 1'b0;
  endtask

  // Fill with out_ready low, then release and check the drain/refill sequence.
  task automatic test_fill_drain();
    int            acc = 0;
    logic [DW-1:0] nxt = 16'h0010;
    logic [DW-1:0] exp_d;
    for (int i = 0; i < 12; i++) begin
      to_drive();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = nxt;
      @(negedge clk);
      if (in_ready === 1'b1) begin
        acc++;
        nxt++;
      end
    end
    checks++;
    if (acc != 2*NS || in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 16'h0010) begin
      errors++;
      $display("FAIL fill: accepted=%0d in_ready=%b valid=%b data=%h, required %0d 0 1 0010", acc, in_ready, out_valid, out_data, 2*NS);
    end
    to_drive();
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_comb_path: in_ready=%b right after out_ready rose, required 0", in_ready);
    end
    for (int i = 0; i < 10; i++) begin
      if (i > 0) to_drive();
      in_valid = (nxt <= 16'h0017);
      in_data  = nxt;
      @(negedge clk);
      if (i <= NS) begin
        checks++;
        if (in_ready !== (i == NS)) begin
          errors++;
          $display("FAIL drain_ready: cycle %0d in_ready=%b, required %b", i, in_ready, (i == NS));
        end
      end
      exp_d = 16'h0010 + 16'(i);
      checks++;
      if (i < 8) begin
        if (out_valid !== 1'b1 || out_data !== exp_d) begin
          errors++;
          $display("FAIL drain_seq: cycle %0d valid=%b data=%h, required 1 %h", i, out_valid, out_data, exp_d);
        end
      end else if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL drain_empty: cycle %0d valid=%b, required 0", i, out_valid);
      end
      if (in_valid === 1'b1 && in_ready === 1'b1) nxt++;
    end
  endtask

  task automatic test_random();
    logic [DW-1:0] nxt = 16'h1000;
    logic          acc_f = 1'b0;
    logic          r;
    for (int i = 0; i < 1000; i++) begin
      to_drive();
      if (acc_f) nxt++;
      in_valid  = 1'($urandom % 2);
      in_data   = nxt;
      out_ready = 1'($urandom % 2);
      r = in_ready;
      out_ready = ~out_ready;
      #1;
      checks++;
      if (in_ready !== r) begin
        errors++;
        $display("FAIL ready_indep: cycle %0d in_ready=%b after out_ready toggle, required %b", i, in_ready, r);
      end
      out_ready = ~out_ready;
      @(negedge clk);
      acc_f = (in_valid === 1'b1 && in_ready === 1'b1);
    end
    to_drive();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4*NS + 4; i++) begin
      @(negedge clk);
      #1;
      if (sb_q.size() == 0 && out_valid === 1'b0) break;
    end
    checks++;
    if (sb_q.size() != 0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL random_drain: %0d words left, out_valid=%b, required 0 and 0", sb_q.size(), out_valid);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      to_drive();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 16'h0020 + 16'(i);
      @(negedge clk);
    end
    to_drive();
    in_valid = 1'b0;
    #1 rstn = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 16'h0000 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid: valid=%b data=%h in_ready=%b, required 0 0000 1", out_valid, out_data, in_ready);
    end
`ifdef PIPE_ELASTIC_OCC_EN
    checks++;
    if (occupancy !== '0) begin
      errors++;
      $display("FAIL reset_mid_occ: got %0d, required 0", occupancy);
    end
`endif
    @(negedge clk);
    #2 rstn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      to_drive();
      out_ready = 1'b1;
      in_valid  = (i == 0);
      in_data   = 16'h00AA;
      @(negedge clk);
      checks++;
      if (i == NS) begin
        if (out_valid !== 1'b1 || out_data !== 16'h00AA) begin
          errors++;
          $display("FAIL reset_restart: cycle %0d valid=%b data=%h, required 1 00aa", i, out_valid, out_data);
        end
      end else if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL reset_restart: cycle %0d valid=%b in_ready=%b, required 0 1", i, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_ignored_input();
    int            acc = 0;
    logic [DW-1:0] nxt = 16'h0030;
    bad_seen = 0;
    for (int i = 0; i < 12; i++) begin
      to_drive();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = nxt;
      @(negedge clk);
      if (in_ready === 1'b1) begin
        acc++;
        nxt++;
      end
      if (acc == 2*NS) break;
    end
    checks++;
    if (acc != 2*NS) begin
      errors++;
      $display("FAIL ignored_fill: accepted=%0d, required %0d", acc, 2*NS);
    end
    for (int i = 0; i < 5; i++) begin
      to_drive();
      in_valid = 1'b1;
      in_data  = 16'h0BAD;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("FAIL ignored_ready: cycle %0d in_ready=%b, required 0", i, in_ready);
      end
    end
    to_drive();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      if (sb_q.size() == 0 && out_valid === 1'b0) break;
    end
    checks++;
    if (bad_seen != 0 || sb_q.size() != 0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL ignored_input: bad words seen=%0d left=%0d valid=%b, required 0 0 0", bad_seen, sb_q.size(), out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_flow();
    test_fill_drain();
    test_random();
    test_reset_mid();
    test_ignored_input();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_elastic.md
Name: pipeline_elastic

Overview:
- Valid/ready elastic pipeline: NUM_STAGES registered stages carry data forward, and backpressure (ready) travels backward through the same stages.
- Every stage is a two-entry skid slice, so no combinational path exists from out_ready to in_ready.
- Used wherever a fixed-latency register pipeline must also absorb downstream stalls without dropping or duplicating data.

Parameters:
- NUM_STAGES, 3, number of register slices; legal range >= 1; sets minimum latency.
- DATA_WIDTH, 16, payload width in bits.

Ports:
- clk  input  1  rising-edge clock.
- rstn  input  1  asynchronous active-low reset; assertion is asynchronous, deassertion is synchronous to clk.
- in_valid  input  1  upstream payload valid.
- in_data  input  DATA_WIDTH  upstream payload.
- in_ready  output  1  stage 0 can accept; driven directly from a flop.
- out_valid  output  1  last stage holds valid data.
- out_data  output  DATA_WIDTH  last-stage payload.
- out_ready  input  1  downstream accepts.

Behaviour:
- Transfer rule: a transfer occurs on a rising edge where valid=1 and ready=1, on either side.
- Reset values: in_ready=1, out_valid=0, out_data=0. All internal data and valid flags clear to 0.
- Reset mid-operation: all in-flight data is discarded. First cycle after deassertion behaves as an empty pipeline.
- Each stage holds a main register (mv, md) and a skid register (sv, sd). A stage's ready_up is the registered value ~sv.
- Stage states and transitions (up = upstream side of the stage, dn = downstream ready):
  - EMPTY (mv=0): up_valid -> FULL, md<=up_data.
  - FULL (mv=1, sv=0):
    - up_valid & dn -> FULL, md<=up_data.
    - up_valid & ~dn -> SKID, sd<=up_data.
    - ~up_valid & dn -> EMPTY.
    - else hold.
  - SKID (mv=1, sv=1): ready_up=0. dn -> FULL, md<=sd, sv<=0. Otherwise hold.
- Input ignored when not ready: in_valid while in_ready=0 is ignored. Data is not sampled and state does not change.
- Chaining: stage k dn = ready_up of stage k+1. The last stage's dn = out_ready.
- Latency: a word accepted on cycle c appears on out_valid/out_data on cycle c+NUM_STAGES when no stalls occur.
- Throughput: 1 word per cycle while out_ready=1.
- Capacity: 2*NUM_STAGES words.
- Ordering: strict FIFO. No loss and no duplication.
- Stall hold rule: while out_valid=1 and out_ready=0, out_data is stable until accepted.
- Full pipeline: in_ready=0 exactly when stage 0 is in SKID.
- Simultaneous out_ready rise with a full pipeline: the output word is consumed that edge. in_ready rises one cycle later (registered), never in the same cycle.
- Mid-stream out_ready deassertion: at most one extra word per stage is absorbed by its skid register. Nothing is overwritten.
- Idle: in_valid=0 with out_ready=1 drains the pipeline, one word per cycle.

Optional Feature:
- Macro: PIPE_ELASTIC_OCC_EN.
- Defined:
  - Adds output port occupancy, width $clog2(2*NUM_STAGES+1), reset 0, registered.
  - Counts words held in the pipeline: +1 on input transfer, -1 on output transfer, unchanged when both or neither occur.
  - Never exceeds 2*NUM_STAGES and never underflows.
- Undefined: port and counter are absent. All other behaviour is identical.

Test Plan:
- Reset/flow (NUM_STAGES=2, DATA_WIDTH=16): hold rstn=0 for 20ns, then release. out_ready=1; push 0x0001, 0x0002, 0x0003 on consecutive cycles -> out_valid rises 2 cycles after the first accept. Outputs are 0x0001, 0x0002, 0x0003 on consecutive cycles; in_ready stays 1.
- Backpressure fill: out_ready=0; push 0x0010..0x0017 with in_valid held 1 -> exactly 4 words accepted. in_ready=0 thereafter; out_data=0x0010 held stable. Occupancy=4 when the macro is defined.
- Drain: from the full state, set out_ready=1 -> outputs 0x0010..0x0013 in order, one per cycle. in_ready returns to 1 one cycle after the first output transfer. Remaining 0x0014..0x0017 are accepted in order with no gaps after refill.
- Random stall: random in_valid and out_ready at 50% each for 1000 cycles, incrementing payload -> the scoreboard sees a strictly incrementing sequence with no loss or duplicates. in_ready is never combinationally dependent on out_ready (checked by toggling out_ready mid-cycle).
- Reset mid-stream: with 3 words in flight, assert rstn=0 asynchronously between edges -> out_valid=0 and out_data=0 immediately. in_ready=1; occupancy=0 when the macro is defined. After release, the first pushed word 0x00AA emerges after 2 cycles.
- Ignored input: in_valid=1 with in_data=0x0BAD while in_ready=0 -> 0x0BAD never appears at out_data.
